score_sequencer: RTL and testbench

- Parametrised successor to the fixed single-voice harmony lookup.
- Steps a beat index at a programmable tempo and fetches a multi-voice score word from an external synchronous score ROM each beat.
- Outputs one registered note code and one onset pulse per voice to the downstream tone generators.
- Adds play/stop/pause control, loop or one-shot mode, tie-based articulation and per-voice mute.

---
 rtl/score_sequencer.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_score_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/score_sequencer.sv
// ---------------------------------------------------------------------------
// score_sequencer
//   Beat-stepped multi-voice score player. A tempo counter advances a beat
//   index. For each beat, one score word is fetched from an external
//   synchronous ROM. For each voice, the block drives a registered note code
//   and a one-cycle onset pulse to the tone generators.
//
// Ports
//   CLOCK_50    in   system clock
//   resetn      in   asynchronous active-low reset
//   play        in   pulse: start from beat 0 (from IDLE or DONE)
//   stop        in   pulse: abort to IDLE, wins over play
//   pause       in   level: freeze tempo and silence outputs in HOLD
//   voice_mute  in   per-voice mute mask
//   rom_addr    out  score ROM address (registered)
//   rom_data    in   score word, valid one cycle after rom_addr changes;
//                    voice v = rom_data[v*(NOTE_W+1) +: NOTE_W+1] = {tie, code}
//   note_code   out  per-voice note code, 0 = silent
//   note_onset  out  per-voice attack pulse
//   beat        out  index of the beat currently sounding
//   playing     out  high in FETCH/LOAD/HOLD
//   done        out  high in DONE
// ---------------------------------------------------------------------------
module score_sequencer #(
    parameter int NUM_VOICES     = 2,
    parameter int NOTE_W         = 6,
    parameter int BEAT_W         = 8,
    parameter int SONG_LEN       = 159,
    parameter int TICKS_PER_BEAT = 6250000,
    parameter int LOOP           = 1
) (
    input  logic                               CLOCK_50,
    input  logic                               resetn,
    input  logic                               play,
    input  logic                               stop,
    input  logic                               pause,
    input  logic [NUM_VOICES-1:0]              voice_mute,
    output logic [BEAT_W-1:0]                  rom_addr,
    input  logic [NUM_VOICES*(NOTE_W+1)-1:0]   rom_data,
    output logic [NUM_VOICES*NOTE_W-1:0]       note_code,
    output logic [NUM_VOICES-1:0]              note_onset,
    output logic [BEAT_W-1:0]                  beat,
    output logic                               playing,
    output logic                               done
);

    localparam int TICK_W = $clog2(TICKS_PER_BEAT);
    localparam int SLOT_W = NOTE_W + 1;

    // HOLD lasts TICKS_PER_BEAT-2 cycles. FETCH and LOAD add one cycle each,
    // so consecutive LOADs are exactly TICKS_PER_BEAT cycles apart.
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BEAT - 3);
    localparam logic [BEAT_W-1:0] ADDR_LAST = BEAT_W'(SONG_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                          state_r;
    state_t                          state_nxt_s;

    logic [BEAT_W-1:0]               rom_addr_r;
    logic [BEAT_W-1:0]               rom_addr_nxt_s;
    logic [BEAT_W-1:0]               beat_r;
    logic [BEAT_W-1:0]               beat_nxt_s;
    logic [TICK_W-1:0]               tick_r;
    logic [TICK_W-1:0]               tick_nxt_s;
    logic [NUM_VOICES*NOTE_W-1:0]    held_r;
    logic [NUM_VOICES*NOTE_W-1:0]    held_nxt_s;
    logic [NUM_VOICES*NOTE_W-1:0]    code_r;
    logic [NUM_VOICES*NOTE_W-1:0]    code_nxt_s;
    logic [NUM_VOICES-1:0]           onset_r;
    logic [NUM_VOICES-1:0]           onset_nxt_s;
    logic                            playing_r;
    logic                            playing_nxt_s;
    logic                            done_r;
    logic                            done_nxt_s;

    logic                            beat_end_s;
    logic                            last_beat_s;
    logic                            silent_s;

    // A beat ends in the last unpaused HOLD cycle.
    assign beat_end_s  = (state_r == ST_HOLD) && !pause && (tick_r == TICK_LAST);
    assign last_beat_s = (rom_addr_r == ADDR_LAST);

    // State register.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; stop overrides every other transition.
    always_comb begin
        state_nxt_s = state_r;
        if (stop) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (play) begin
                        state_nxt_s = ST_FETCH;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_FETCH: state_nxt_s = ST_LOAD;
                ST_LOAD:  state_nxt_s = ST_HOLD;
                ST_HOLD: begin
                    if (beat_end_s) begin
                        if (last_beat_s && (LOOP == 0)) begin
                            state_nxt_s = ST_DONE;
                        end else begin
                            state_nxt_s = ST_FETCH;
                        end
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                ST_DONE: begin
                    if (play) begin
                        state_nxt_s = ST_FETCH;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Datapath and output next values, derived from the current state.
    always_comb begin
        rom_addr_nxt_s = rom_addr_r;
        beat_nxt_s     = beat_r;
        tick_nxt_s     = tick_r;
        held_nxt_s     = held_r;
        onset_nxt_s    = '0;
        if (stop) begin
            rom_addr_nxt_s = '0;
            beat_nxt_s     = '0;
            tick_nxt_s     = '0;
            held_nxt_s     = '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (play) begin
                        rom_addr_nxt_s = '0;
                        tick_nxt_s     = '0;
                    end else begin
                        rom_addr_nxt_s = rom_addr_r;
                    end
                end
                ST_FETCH: begin
                    rom_addr_nxt_s = rom_addr_r;
                end
                ST_LOAD: begin
                    beat_nxt_s = rom_addr_r;
                    tick_nxt_s = '0;
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        held_nxt_s[v*NOTE_W +: NOTE_W] = rom_data[v*SLOT_W +: NOTE_W];
                        // A tie continues the previous note, so it never attacks.
                        onset_nxt_s[v] = !rom_data[v*SLOT_W + NOTE_W]
                                         && (rom_data[v*SLOT_W +: NOTE_W] != NOTE_W'(0))
                                         && !voice_mute[v];
                    end
                end
                ST_HOLD: begin
                    if (pause) begin
                        tick_nxt_s = tick_r;
                    end else if (beat_end_s) begin
                        // Wrap modulo SONG_LEN, not modulo 2^BEAT_W.
                        if (last_beat_s) begin
                            rom_addr_nxt_s = '0;
                        end else begin
                            rom_addr_nxt_s = rom_addr_r + BEAT_W'(1);
                        end
                    end else begin
                        tick_nxt_s = tick_r + TICK_W'(1);
                    end
                end
                default: begin
                    rom_addr_nxt_s = '0;
                    beat_nxt_s     = '0;
                    tick_nxt_s     = '0;
                    held_nxt_s     = '0;
                end
            endcase
        end

        // Pause silences the outputs but keeps the held notes, so they
        // return on release without a fresh onset.
        silent_s = (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_DONE) || pause;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (silent_s || voice_mute[v]) begin
                code_nxt_s[v*NOTE_W +: NOTE_W] = '0;
            end else begin
                code_nxt_s[v*NOTE_W +: NOTE_W] = held_nxt_s[v*NOTE_W +: NOTE_W];
            end
        end

        playing_nxt_s = (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_LOAD)
                        || (state_nxt_s == ST_HOLD);
        done_nxt_s    = (state_nxt_s == ST_DONE);
    end

    // Datapath and output registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            rom_addr_r <= '0;
            beat_r     <= '0;
            tick_r     <= '0;
            held_r     <= '0;
            code_r     <= '0;
            onset_r    <= '0;
            playing_r  <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            rom_addr_r <= rom_addr_nxt_s;
            beat_r     <= beat_nxt_s;
            tick_r     <= tick_nxt_s;
            held_r     <= held_nxt_s;
            code_r     <= code_nxt_s;
            onset_r    <= onset_nxt_s;
            playing_r  <= playing_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

    assign rom_addr   = rom_addr_r;
    assign beat       = beat_r;
    assign note_code  = code_r;
    assign note_onset = onset_r;
    assign playing    = playing_r;
    assign done       = done_r;

    score_sequencer_chk #(
        .NUM_VOICES (NUM_VOICES),
        .BEAT_W     (BEAT_W),
        .SONG_LEN   (SONG_LEN)
    ) u_chk (
        .clk        (CLOCK_50),
        .rst_n      (resetn),
        .rom_addr   (rom_addr_r),
        .note_onset (onset_r),
        .playing    (playing_r),
        .done       (done_r)
    );

endmodule

// ---------------------------------------------------------------------------
// score_sequencer_chk
//   Invariant checks on the sequencer outputs.
//
// Ports (all inputs)
//   clk, rst_n                       clock and active-low reset
//   rom_addr, note_onset, playing, done   observed sequencer outputs
// ---------------------------------------------------------------------------
module score_sequencer_chk #(
    parameter int NUM_VOICES = 2,
    parameter int BEAT_W     = 8,
    parameter int SONG_LEN   = 159
) (
    input logic                  clk,
    input logic                  rst_n,
    input logic [BEAT_W-1:0]     rom_addr,
    input logic [NUM_VOICES-1:0] note_onset,
    input logic                  playing,
    input logic                  done
);

    // playing and done reflect mutually exclusive states.
    a_excl: assert property (@(posedge clk) disable iff (!rst_n) !(playing && done));

    // An attack can only happen while a score is playing.
    a_onset: assert property (@(posedge clk) disable iff (!rst_n)
                              (note_onset != '0) |-> playing);

    // The ROM address never leaves the score.
    a_addr: assert property (@(posedge clk) disable iff (!rst_n)
                             32'(rom_addr) < 32'(SONG_LEN));

endmodule

// File: tb/tb_score_sequencer.sv
module tb_score_sequencer;

    localparam int NV  = 2;
    localparam int NW  = 6;
    localparam int BW  = 8;
    localparam int SL  = 3;
    localparam int TPB = 4;

    logic           clk = 1'b0;
    logic           resetn;
    logic           play;
    logic           stop;
    logic           pause;
    logic [NV-1:0]  voice_mute;

    logic [BW-1:0]        rom_addr_l, rom_addr_o;
    logic [NV*(NW+1)-1:0] rom_data_l, rom_data_o;
    logic [NV*NW-1:0]     code_l, code_o;
    logic [NV-1:0]        onset_l, onset_o;
    logic [BW-1:0]        beat_l, beat_o;
    logic                 playing_l, playing_o, done_l, done_o;

    int check_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    // Score: beat 0 {(t0,15),(t0,3)}, beat 1 {(t1,15),(t0,0)}, beat 2 {(t0,6),(t0,8)}.
    function automatic logic [13:0] rom_word(input logic [BW-1:0] a);
        case (a)
            8'd0:    rom_word = {7'd3, 7'd15};
            8'd1:    rom_word = {7'd0, 1'b1, 6'd15};
            8'd2:    rom_word = {7'd8, 7'd6};
            default: rom_word = 14'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        rom_data_l <= rom_word(rom_addr_l);
        rom_data_o <= rom_word(rom_addr_o);
    end

    score_sequencer #(.NUM_VOICES(NV), .NOTE_W(NW), .BEAT_W(BW), .SONG_LEN(SL),
                      .TICKS_PER_BEAT(TPB), .LOOP(1)) u_dut_loop (
        .CLOCK_50(clk), .resetn(resetn), .play(play), .stop(stop), .pause(pause),
        .voice_mute(voice_mute), .rom_addr(rom_addr_l), .rom_data(rom_data_l),
        .note_code(code_l), .note_onset(onset_l), .beat(beat_l),
        .playing(playing_l), .done(done_l));

    score_sequencer #(.NUM_VOICES(NV), .NOTE_W(NW), .BEAT_W(BW), .SONG_LEN(SL),
                      .TICKS_PER_BEAT(TPB), .LOOP(0)) u_dut_once (
        .CLOCK_50(clk), .resetn(resetn), .play(play), .stop(stop), .pause(pause),
        .voice_mute(voice_mute), .rom_addr(rom_addr_o), .rom_data(rom_data_o),
        .note_code(code_o), .note_onset(onset_o), .beat(beat_o),
        .playing(playing_o), .done(done_o));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        play = 1'b0; stop = 1'b0; pause = 1'b0; voice_mute = '0;
        resetn = 1'b0;
        step(1);
        resetn = 1'b1;
        step(1);
    endtask

    // Pulse play for one cycle; returns positioned in cycle 1.
    task automatic start();
        play = 1'b1;
        step(1);
        play = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_code",    code_l,    32'd0);
        check("rst_onset",   onset_l,   32'd0);
        check("rst_playing", playing_l, 32'd0);
        check("rst_done",    done_o,    32'd0);
        check("rst_addr",    rom_addr_l, 32'd0);
        check("rst_beat",    beat_l,    32'd0);

        // Basic playback and loop/one-shot end.
        start();                                           // cycle 1
        check("c1_addr",    rom_addr_l, 32'd0);
        check("c1_playing", playing_l,  32'd1);
        step(2);                                           // cycle 3
        check("b0_code",  code_l,  {20'd0, 6'd3, 6'd15});
        check("b0_onset", onset_l, 32'b11);
        check("b0_beat",  beat_l,  32'd0);
        step(1);                                           // cycle 4
        check("b0_onset_end", onset_l, 32'b00);
        step(3);                                           // cycle 7
        check("b1_code",  code_l,  {20'd0, 6'd0, 6'd15});
        check("b1_onset", onset_l, 32'b00);
        check("b1_beat",  beat_l,  32'd1);
        step(4);                                           // cycle 11
        check("b2_code",   code_l,  {20'd0, 6'd8, 6'd6});
        check("b2_onset",  onset_l, 32'b11);
        check("b2_beat",   beat_l,  32'd2);
        check("b2_code_o", code_o,  {20'd0, 6'd8, 6'd6});
        step(2);                                           // cycle 13
        check("wrap_addr",    rom_addr_l, 32'd0);
        check("wrap_playing", playing_l,  32'd1);
        check("once_done",    done_o,     32'd1);
        check("once_playing", playing_o,  32'd0);
        check("once_code",    code_o,     32'd0);
        check("once_beat",    beat_o,     32'd2);
        step(2);                                           // cycle 15
        check("wrap_beat",  beat_l,  32'd0);
        check("wrap_onset", onset_l, 32'b11);
        check("wrap_code",  code_l,  {20'd0, 6'd3, 6'd15});
        start();                                           // cycle 16
        check("restart_addr",    rom_addr_o, 32'd0);
        check("restart_playing", playing_o,  32'd1);
        check("restart_done",    done_o,     32'd0);
        check("ignore_play_beat", beat_l,    32'd0);
        step(2);                                           // cycle 18
        check("restart_onset", onset_o, 32'b11);
        check("restart_beat",  beat_o,  32'd0);
        check("restart_code",  code_o,  {20'd0, 6'd3, 6'd15});

        // Pause for 5 cycles during beat 0.
        do_reset();
        start();
        step(2);                                           // cycle 3
        pause = 1'b1;
        step(1);                                           // cycle 4
        check("pause_code", code_l, 32'd0);
        step(3);                                           // cycle 7
        check("pause_beat",    beat_l,    32'd0);
        check("pause_playing", playing_l, 32'd1);
        step(1);                                           // cycle 8
        pause = 1'b0;
        check("pause_code_last", code_l, 32'd0);
        step(1);                                           // cycle 9
        check("resume_code",  code_l,  {20'd0, 6'd3, 6'd15});
        check("resume_onset", onset_l, 32'b00);
        step(2);                                           // cycle 11
        check("delay_beat_old", beat_l, 32'd0);
        step(1);                                           // cycle 12
        check("delay_beat_new", beat_l, 32'd1);
        check("delay_code",     code_l, {20'd0, 6'd0, 6'd15});

        // Mute voice 1 during beat 0.
        do_reset();
        voice_mute = 2'b10;
        start();
        step(2);                                           // cycle 3
        check("mute_code",  code_l,  {20'd0, 6'd0, 6'd15});
        check("mute_onset", onset_l, 32'b01);
        voice_mute = 2'b00;
        step(1);                                           // cycle 4
        check("unmute_code",  code_l,  {20'd0, 6'd3, 6'd15});
        check("unmute_onset", onset_l, 32'b00);

        // Stop and play together during beat 1 HOLD.
        do_reset();
        start();
        step(6);                                           // cycle 7
        check("pre_stop_addr", rom_addr_l, 32'd1);
        stop = 1'b1;
        play = 1'b1;
        step(1);                                           // cycle 8
        stop = 1'b0;
        play = 1'b0;
        check("stop_playing", playing_l,  32'd0);
        check("stop_done",    done_l,     32'd0);
        check("stop_code",    code_l,     32'd0);
        check("stop_onset",   onset_l,    32'd0);
        check("stop_addr",    rom_addr_l, 32'd0);
        check("stop_beat",    beat_l,     32'd0);
        step(2);
        check("stop_stays_idle", playing_l, 32'd0);

        // Asynchronous reset during beat 1 HOLD.
        start();
        step(6);                                           // cycle 7
        check("pre_rst_beat", beat_l, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_playing", playing_l,  32'd0);
        check("arst_addr",    rom_addr_l, 32'd0);
        check("arst_beat",    beat_l,     32'd0);
        check("arst_code",    code_l,     32'd0);
        step(1);
        resetn = 1'b1;
        step(2);
        check("arst_idle", playing_l, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
